// File: rtl/kgp_alu_pkg.sv
// Shared opcode, flag-index and shift-mode definitions for the KGPMini execute-stage ALU.
package kgp_alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [4:0] OP_ADD  = 5'b10000;
  localparam logic [4:0] OP_COMP = 5'b10001;
  localparam logic [4:0] OP_SUB  = 5'b10010;
  localparam logic [4:0] OP_AND  = 5'b00001;
  localparam logic [4:0] OP_XOR  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b01000;
  localparam logic [4:0] OP_SRL  = 5'b01001;
  localparam logic [4:0] OP_SRA  = 5'b01010;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_SIGN  = 2;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_mode_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational 5-stage logarithmic barrel shifter (SLL/SRL/SRA) with last-bit-out carry.
// Zero latency; no flow control.
module alu_shifter
  import kgp_alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [W-1:0] a,
  input  logic [4:0]   shamt,
  input  shift_mode_t  mode,
  output logic [W-1:0] res,
  output logic         carry
);

  logic [W-1:0] v;
  logic         c;

  // Each active stage records the bit it drops; the last active stage leaves
  // exactly a[W-n] (left) or a[n-1] (right) in c.
  always_comb begin
    v = a;
    c = 1'b0;
    for (int s = 0; s < 5; s++) begin
      if (shamt[s]) begin
        case (mode)
          SH_SLL: begin
            c = v[W - (1 << s)];
            v = v << (1 << s);
          end
          SH_SRL: begin
            c = v[(1 << s) - 1];
            v = v >> (1 << s);
          end
          SH_SRA: begin
            c = v[(1 << s) - 1];
            v = $signed(v) >>> (1 << s);
          end
          default: begin
            c = 1'b0;
            v = '0;
          end
        endcase
      end
    end
  end

  assign res   = v;
  assign carry = c;

endmodule

// File: rtl/kgp_alu.sv
// KGPMini execute-stage ALU: nine ops on a/b, result and carry/zero/sign registered.
// One cycle latency, a new op accepted every cycle, no backpressure.
module kgp_alu
  import kgp_alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       controls,
  output logic [2:0]       flags,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] out_d, out_q;
  logic [2:0]       flags_d, flags_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sh_res;
  logic             sh_carry;
  shift_mode_t      sh_mode;
  logic             carry;
  logic             op_valid;

  always_comb begin
    sh_mode = SH_SLL;
    case (controls)
      OP_SRL:  sh_mode = SH_SRL;
      OP_SRA:  sh_mode = SH_SRA;
      default: sh_mode = SH_SLL;
    endcase
  end

  alu_shifter #(.W(WIDTH)) u_shifter (
    .a     (a),
    .shamt (b[4:0]),
    .mode  (sh_mode),
    .res   (sh_res),
    .carry (sh_carry)
  );

  always_comb begin
    sum      = '0;
    out_d    = '0;
    carry    = 1'b0;
    op_valid = 1'b1;
    case (controls)
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        out_d = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      OP_COMP: begin
        sum   = {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        out_d = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      OP_SUB: begin
        sum   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        out_d = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      OP_AND: out_d = a & b;
      OP_XOR: out_d = a ^ b;
      OP_OR:  out_d = a | b;
      OP_SLL, OP_SRL, OP_SRA: begin
        out_d = sh_res;
        carry = sh_carry;
      end
      default: op_valid = 1'b0;
    endcase
  end

  // Undefined opcodes report all-clear flags, not zero=1 for their zero result.
  always_comb begin
    flags_d             = 3'b000;
    flags_d[FLAG_CARRY] = op_valid & carry;
    flags_d[FLAG_ZERO]  = op_valid & (out_d == '0);
    flags_d[FLAG_SIGN]  = op_valid & out_d[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      flags_q <= 3'b000;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign out   = out_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_kgp_alu.sv
// Directed scoreboard bench for kgp_alu: expectations queued at issue, checked one cycle later.
module tb_kgp_alu;

  localparam logic [4:0] C_ADD  = 5'b10000;
  localparam logic [4:0] C_COMP = 5'b10001;
  localparam logic [4:0] C_SUB  = 5'b10010;
  localparam logic [4:0] C_AND  = 5'b00001;
  localparam logic [4:0] C_XOR  = 5'b00010;
  localparam logic [4:0] C_OR   = 5'b00011;
  localparam logic [4:0] C_SLL  = 5'b01000;
  localparam logic [4:0] C_SRL  = 5'b01001;
  localparam logic [4:0] C_SRA  = 5'b01010;

  typedef struct {
    string       tag;
    logic [31:0] out;
    logic [2:0]  flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  controls;
  logic [2:0]  flags;
  logic [31:0] out;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  kgp_alu dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .controls (controls),
    .flags    (flags),
    .out      (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] eo, input logic [2:0] ef);
    tests++;
    assert ({out, flags} === {eo, ef})
    else begin
      fails++;
      $error("FAIL %s: out=%h flags=%b, expected out=%h flags=%b", tag, out, flags, eo, ef);
    end
  endtask

  task automatic issue(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [4:0] ic, input logic [31:0] eo, input logic [2:0] ef);
    exp_t e;
    @(negedge clk);
    a        = ia;
    b        = ib;
    controls = ic;
    e.tag    = tag;
    e.out    = eo;
    e.flags  = ef;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: scoreboard empty, expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, e.out, e.flags);
    end
  endtask

  initial begin
    rst      = 1'b1;
    a        = 32'h1234_5678;
    b        = 32'h0000_0001;
    controls = C_ADD;
    #1;
    chk("reset_state", 32'h0, 3'b000);
    @(posedge clk);
    #1;
    chk("reset_held_edge", 32'h0, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // flags are {sign, zero, carry}
    issue("add_512_512",   32'd512,        32'd512,        C_ADD,  32'd1024,       3'b000);
    issue("add_512_1024",  32'd512,        32'd1024,       C_ADD,  32'd1536,       3'b000);
    issue("add_150_150",   32'd150,        32'd150,        C_ADD,  32'd300,        3'b000);
    issue("add_1243_10",   32'd1243,       32'd10,         C_ADD,  32'd1253,       3'b000);
    issue("add_wrap",      32'hFFFF_FFFF,  32'h0000_0001,  C_ADD,  32'h0,          3'b011);
    issue("add_carry_nz",  32'hFFFF_FFFF,  32'h0000_0002,  C_ADD,  32'h1,          3'b001);
    issue("sub_eq",        32'd150,        32'd150,        C_SUB,  32'h0,          3'b011);
    issue("sub_neg",       32'd10,         32'd1243,       C_SUB,  32'hFFFF_FB2F,  3'b100);
    issue("sub_pos",       32'd5,          32'd3,          C_SUB,  32'h2,          3'b001);
    issue("comp_5",        32'hDEAD_BEEF,  32'd5,          C_COMP, 32'hFFFF_FFFB,  3'b100);
    issue("comp_0",        32'h0,          32'h0,          C_COMP, 32'h0,          3'b011);
    issue("sra_neg4",      32'h8000_0000,  32'd4,          C_SRA,  32'hF800_0000,  3'b100);
    issue("srl_4",         32'h8000_0000,  32'd4,          C_SRL,  32'h0800_0000,  3'b000);
    issue("sll_1_31",      32'h0000_0001,  32'd31,         C_SLL,  32'h8000_0000,  3'b100);
    issue("sll_b32",       32'h1234_5678,  32'd32,         C_SLL,  32'h1234_5678,  3'b000);
    issue("sra_neg31",     32'h8000_0000,  32'd31,         C_SRA,  32'hFFFF_FFFF,  3'b100);
    issue("srl_carry",     32'h0000_000F,  32'd2,          C_SRL,  32'h0000_0003,  3'b001);
    issue("sll_carry",     32'hC000_0000,  32'd1,          C_SLL,  32'h8000_0000,  3'b101);
    issue("sra_pos_hi_b",  32'h7000_0000,  32'hFFFF_FFE4,  C_SRA,  32'h0700_0000,  3'b000);
    issue("and",           32'hF0F0_F0F0,  32'h0FF0_0FF0,  C_AND,  32'h00F0_00F0,  3'b000);
    issue("xor_eq",        32'hA5A5_5A5A,  32'hA5A5_5A5A,  C_XOR,  32'h0,          3'b010);
    issue("or",            32'h0000_0F00,  32'h0000_00F0,  C_OR,   32'h0000_0FF0,  3'b000);
    issue("illegal_1f",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'b11111, 32'h0,        3'b000);
    issue("illegal_00",    32'h0,          32'h0,          5'b00000, 32'h0,        3'b000);

    // Reset mid-stream: a live result is present, an op is in flight, rst clears at once.
    issue("pre_reset",     32'd1,          32'd2,          C_ADD,  32'd3,          3'b000);
    @(negedge clk);
    a        = 32'd7;
    b        = 32'd8;
    controls = C_ADD;
    #2;
    rst = 1'b1;
    #1;
    chk("reset_async", 32'h0, 3'b000);
    @(posedge clk);
    #1;
    chk("reset_hold", 32'h0, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    issue("post_reset",    32'h8000_0000,  32'h8000_0000,  C_ADD,  32'h0,          3'b011);
    issue("post_reset2",   32'd100,        32'd1,          C_SUB,  32'd99,         3'b001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
